// File: rtl/div_result_bcd.sv
// Captures divider quotient/remainder on a rising start and converts both to packed BCD
// with two parallel shift-and-add-3 datapaths sharing one FSM and iteration counter.
module div_result_bcd #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [WIDTH-1:0]      quotient,
    input  logic [WIDTH-1:0]      rem,
    output logic [4*DIGITS-1:0]   q_bcd,
    output logic [4*DIGITS-1:0]   r_bcd,
    output logic                  busy,
    output logic                  done
);

    localparam int unsigned BW = 4 * DIGITS;
    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [0:0] {StIdle, StShift} state_e;

    state_e           state_q;
    logic [CW-1:0]    cnt_q;
    logic             start_q;
    logic [WIDTH-1:0] q_op_q, r_op_q;
    logic [BW-1:0]    q_acc_q, r_acc_q;

    logic [WIDTH-1:0] q_op_d, r_op_d;
    logic [BW-1:0]    q_acc_d, r_acc_d;
    logic             accept;
    logic             last;

    // Add 3 to every digit >= 5 so the following left shift carries correctly into the next digit.
    function automatic logic [BW-1:0] adjust(input logic [BW-1:0] acc);
        logic [BW-1:0] res;
        res = acc;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (acc[4*i +: 4] >= 4'd5) res[4*i +: 4] = acc[4*i +: 4] + 4'd3;
        end
        return res;
    endfunction

    always_comb begin
        {q_acc_d, q_op_d} = {adjust(q_acc_q), q_op_q} << 1;
        {r_acc_d, r_op_d} = {adjust(r_acc_q), r_op_q} << 1;
        accept = start && !start_q && (state_q == StIdle);
        last   = (cnt_q == CW'(WIDTH - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            start_q <= 1'b0;
            q_op_q  <= '0;
            r_op_q  <= '0;
            q_acc_q <= '0;
            r_acc_q <= '0;
            q_bcd   <= '0;
            r_bcd   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            // Tracks start in every state so a level held across completion never retriggers.
            start_q <= start;
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        q_op_q  <= quotient;
                        r_op_q  <= rem;
                        q_acc_q <= '0;
                        r_acc_q <= '0;
                        cnt_q   <= '0;
                        busy    <= 1'b1;
                        done    <= 1'b0;
                        state_q <= StShift;
                    end
                end
                StShift: begin
                    q_acc_q <= q_acc_d;
                    r_acc_q <= r_acc_d;
                    q_op_q  <= q_op_d;
                    r_op_q  <= r_op_d;
                    cnt_q   <= cnt_q + CW'(1);
                    if (last) begin
                        q_bcd   <= q_acc_d;
                        r_bcd   <= r_acc_d;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
